matmul_ctrl: RTL and testbench
==============================

# matmul_ctrl

Sequencer for the 2x2 matrix multiplier. It accepts two 2x2 operand matrices A and B and drives the shared dot-product `alu` four times, once per result element. It captures each 18-bit dot product into the result matrix C and signals completion. It sits between the host-facing register/port layer and the single `alu` instance; the `alu` is a peer instance in the top level, not a child of this block.

## Interface
Parameters:
- `W`, 8: operand element width.
- `OW`, 18: result element width; must equal the `alu` output width.
- `TIMEOUT_CYCLES`, 64: watchdog limit per element. Only used with `MATMUL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a00,a01,a10,a11`  in  W  matrix A, `aRC` = row R, column C.
- `b00,b01,b10,b11`  in  W  matrix B.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse; C is valid from this cycle.
- `c00,c01,c10,c11`  out  OW  result registers; held until the next accepted `start`.
- `alu_start`  out  1  start strobe to `alu`.
- `alu_row0,alu_row1,alu_col0,alu_col1`  out  W  `alu` operands.
- `alu_out`  in  OW  `alu` result.
- `alu_complete`  in  1  `alu` completion flag.
- `err`  out  1  timeout flag. This port exists only with `MATMUL_TIMEOUT_EN`.

## Operation
- States: IDLE → ISSUE → WAIT → (ISSUE for the next element | DONE) → IDLE.
- **IDLE:**
  - On `start`=1, latch all eight operands into internal registers.
  - Set element index `k`=0, clear C to 0, then go to ISSUE.
- **ISSUE (1 cycle):**
  - Drive `alu_start`=1.
  - Drive operands for element `k`:
    - k=0 (c00): row=(a00,a01), col=(b00,b10).
    - k=1 (c01): row=(a00,a01), col=(b01,b11).
    - k=2 (c10): row=(a10,a11), col=(b00,b10).
    - k=3 (c11): row=(a10,a11), col=(b01,b11).
  - Mapping: `alu_row0`/`alu_row1` = the two A elements of the row; `alu_col0`/`alu_col1` = the two B elements of the column.
- **WAIT:**
  - `alu_start`=0; operands stay stable.
  - Capture is triggered by a *rising edge* of `alu_complete` (compare against a registered copy). A level held high from a previous operation is ignored.
  - On the edge, write `alu_out` into the C register for element `k`. Then go to ISSUE with `k`+1, or to DONE if `k`=3.
- **DONE (1 cycle):** `done`=1, `busy`=0, then return to IDLE.
- `start` while not in IDLE is ignored. Operand inputs may change freely after acceptance.
- No arithmetic is performed here; C values pass through from `alu_out` unmodified at OW bits.
- Reset (including mid-operation):
  - State goes to IDLE and `k`=0.
  - Outputs: `alu_start`=0, `busy`=0, `done`=0, C=0, `err`=0, `alu_*` operands=0.
  - A pending `alu` result is discarded.

## Timing
- `start` sampled high at edge T → ISSUE during cycle T+1.
- Per element: 1 ISSUE cycle plus WAIT cycles until the `alu_complete` rise is registered.
- With an `alu` whose `alu_complete` rises L cycles after it samples `alu_start`:
  - `done` fires 4·(L+2) cycles after the accepting edge.
  - `busy` is high for the whole interval.
- `done` and the final C write become visible in the same cycle.
- `start` high in the DONE cycle is ignored. A new request is accepted in IDLE from the next cycle on.

## Configuration
- `MATMUL_TIMEOUT_EN` defined:
  - WAIT counts cycles; the counter clears on entry to ISSUE.
  - If it reaches `TIMEOUT_CYCLES` with no `alu_complete` rise:
    - Go to DONE with `err`=1 in the same cycle as `done`.
    - Unfinished C elements stay 0.
  - `err` holds until the next accepted `start` or reset.
- Not defined: no counter and no `err` port; WAIT waits indefinitely.

## Structure
- Package `matmul_pkg`:
  - Width constants `W`/`OW` defaults.
  - State enum (`S_IDLE, S_ISSUE, S_WAIT, S_DONE`).
  - 2-bit element index typedef.
  - Element-to-operand select constants.
- Optional sub-module `matmul_watchdog` (load/clear, count, expire), instantiated only under `MATMUL_TIMEOUT_EN`. Everything else is flat in `matmul_ctrl`.

## Test plan
- Bench `alu` stub with L=3, computing row0·col0+row1·col1.
- **Identity:** A=[[1,0],[0,1]], B=[[5,6],[7,8]] → C=[[5,6],[7,8]]; `done` exactly 20 cycles after acceptance; one-cycle pulse.
- **Ordering:** A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]]; `alu_start` pulses exactly 4 times with the listed operand pairs.
- **Max values:** all elements 0xFF → every C element = 130050 (0x1FC02), no truncation.
- **Ignored start:** `start` re-pulsed during WAIT with different A → result unchanged, no extra `alu_start`. `alu_complete` held high between elements → each capture only on a new rise.
- **Reset:** `rst` asserted during element 2 → next cycle IDLE, C=0, `busy`=0, no `done`. A new `start` then completes normally.
- **Timeout (with `MATMUL_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** stub never completes element 1 → `done`=1 and `err`=1 together; c00 valid, others 0. `err` clears on the next `start`.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
// Element k maps to row i = k[1] and column j = k[0] of the result.
package matmul_pkg;

  localparam int W_DEF  = 8;
  localparam int OW_DEF = 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef logic [1:0] elem_t;

  // Bit k set: element k takes A row 1 / B column 1 (operands stored as x00,x01,x10,x11).
  localparam logic [3:0] ROW1_SEL  = 4'b1100;
  localparam logic [3:0] COL1_SEL  = 4'b1010;
  localparam elem_t      LAST_ELEM = 2'd3;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Handshake bundle between the matmul sequencer (master) and the shared dot-product alu (slave).
interface matmul_ctrl_if
  import matmul_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int OW = OW_DEF
);
  logic          alu_start;
  logic [W-1:0]  alu_row0;
  logic [W-1:0]  alu_row1;
  logic [W-1:0]  alu_col0;
  logic [W-1:0]  alu_col1;
  logic [OW-1:0] alu_out;
  logic          alu_complete;

  modport master (
    output alu_start, alu_row0, alu_row1, alu_col0, alu_col1,
    input  alu_out, alu_complete
  );

  modport slave (
    input  alu_start, alu_row0, alu_row1, alu_col0, alu_col1,
    output alu_out, alu_complete
  );
endinterface

// File: rtl/matmul_watchdog.sv
// Per-element WAIT cycle counter for matmul_ctrl; built only when MATMUL_TIMEOUT_EN is defined.
module matmul_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the LIMIT-th WAIT cycle of the current element.
  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer driving the shared dot-product alu once per element of C = A x B (2x2).
// Optional MATMUL_TIMEOUT_EN adds a per-element watchdog and the err output.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int W              = W_DEF,
  parameter int OW             = OW_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a00,
  input  logic [W-1:0]  a01,
  input  logic [W-1:0]  a10,
  input  logic [W-1:0]  a11,
  input  logic [W-1:0]  b00,
  input  logic [W-1:0]  b01,
  input  logic [W-1:0]  b10,
  input  logic [W-1:0]  b11,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] c00,
  output logic [OW-1:0] c01,
  output logic [OW-1:0] c10,
  output logic [OW-1:0] c11,
`ifdef MATMUL_TIMEOUT_EN
  output logic          err,
`endif
  matmul_ctrl_if.master alu
);
  state_e        state_q, state_d;
  elem_t         k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          alu_start_q, alu_start_d;
  logic          comp_q, comp_d;
  logic          rise;
  logic [W-1:0]  a_q [4];
  logic [W-1:0]  a_d [4];
  logic [W-1:0]  b_q [4];
  logic [W-1:0]  b_d [4];
  logic [OW-1:0] c_q [4];
  logic [OW-1:0] c_d [4];
  logic [W-1:0]  row0_q, row0_d, row1_q, row1_d;
  logic [W-1:0]  col0_q, col0_d, col1_q, col1_d;
`ifdef MATMUL_TIMEOUT_EN
  logic          err_q, err_d;
  logic          expired;

  matmul_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_ISSUE),
    .en      (state_q == S_WAIT),
    .expired (expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    alu_start_d = 1'b0;
    comp_d      = alu.alu_complete;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    row0_d      = row0_q;
    row1_d      = row1_q;
    col0_d      = col0_q;
    col1_d      = col1_q;
`ifdef MATMUL_TIMEOUT_EN
    err_d       = err_q;
`endif
    // Only a fresh rise counts; a level left over from the previous element is ignored.
    rise = alu.alu_complete & ~comp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d         = '{a00, a01, a10, a11};
          b_d         = '{b00, b01, b10, b11};
          c_d         = '{default: '0};
          k_d         = '0;
          busy_d      = 1'b1;
          alu_start_d = 1'b1;
          state_d     = S_ISSUE;
`ifdef MATMUL_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (rise) begin
          c_d[k_q] = alu.alu_out;
          if (k_q == LAST_ELEM) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d         = k_q + 1'b1;
            alu_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
`ifdef MATMUL_TIMEOUT_EN
        else if (expired) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are registered alongside the strobe, from the freshly latched copy on accept.
    if (alu_start_d) begin
      row0_d = a_d[{ROW1_SEL[k_d], 1'b0}];
      row1_d = a_d[{ROW1_SEL[k_d], 1'b1}];
      col0_d = b_d[{1'b0, COL1_SEL[k_d]}];
      col1_d = b_d[{1'b1, COL1_SEL[k_d]}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_start_q <= 1'b0;
      comp_q      <= 1'b0;
      c_q         <= '{default: '0};
      row0_q      <= '0;
      row1_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
`ifdef MATMUL_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_start_q <= alu_start_d;
      comp_q      <= comp_d;
      c_q         <= c_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
`ifdef MATMUL_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign c00           = c_q[0];
  assign c01           = c_q[1];
  assign c10           = c_q[2];
  assign c11           = c_q[3];
  assign alu.alu_start = alu_start_q;
  assign alu.alu_row0  = row0_q;
  assign alu.alu_row1  = row1_q;
  assign alu.alu_col0  = col0_q;
  assign alu.alu_col1  = col1_q;
`ifdef MATMUL_TIMEOUT_EN
  assign err           = err_q;
`endif
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: alu stub with programmable latency, table-driven and random matrix products.
module tb_matmul_ctrl;
  import matmul_pkg::*;

  localparam int W  = 8;
  localparam int OW = 18;
`ifdef MATMUL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef logic [3:0][W-1:0]  mat_t;
  typedef logic [3:0][OW-1:0] res_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
    res_t c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0]  a00, a01, a10, a11, b00, b01, b10, b11;
  logic          busy, done;
  logic [OW-1:0] c00, c01, c10, c11;
`ifdef MATMUL_TIMEOUT_EN
  logic          err;
`endif

  matmul_ctrl_if #(.W(W), .OW(OW)) bus ();

  matmul_ctrl #(.W(W), .OW(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .busy(busy), .done(done),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
`ifdef MATMUL_TIMEOUT_EN
    .err(err),
`endif
    .alu(bus)
  );

  always #5 clk = ~clk;

  // alu stub: complete rises stub_lat cycles after alu_start is sampled.
  // Hold mode keeps complete high until one cycle before the next rise.
  int   stub_lat = 3;
  bit   stub_hold = 1'b0;
  int   stall_at = -1;
  int   starts_total = 0;
  logic pend = 1'b0;
  int   scnt = 0;
  logic [W-1:0]  s_r0 = '0, s_r1 = '0, s_c0 = '0, s_c1 = '0;
  logic          comp = 1'b0;
  logic [OW-1:0] aout = '0;
  logic [4*W-1:0] trace [$];

  assign bus.alu_complete = comp;
  assign bus.alu_out      = aout;

  always @(posedge clk) begin
    if (bus.alu_start) begin
      pend <= (starts_total != stall_at);
      scnt <= 1;
      s_r0 <= bus.alu_row0;
      s_r1 <= bus.alu_row1;
      s_c0 <= bus.alu_col0;
      s_c1 <= bus.alu_col1;
      trace.push_back({bus.alu_row0, bus.alu_row1, bus.alu_col0, bus.alu_col1});
      starts_total <= starts_total + 1;
      if (!stub_hold) comp <= 1'b0;
    end else if (pend) begin
      if (scnt == stub_lat) begin
        pend <= 1'b0;
        comp <= 1'b1;
        aout <= OW'(int'(s_r0) * int'(s_c0) + int'(s_r1) * int'(s_c1));
      end else begin
        if (stub_hold && scnt == stub_lat - 1) comp <= 1'b0;
        scnt <= scnt + 1;
      end
    end else if (!stub_hold) begin
      comp <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: C[i][j] = sum over m of A[i][m]*B[m][j]; element k = 2*i + j.
  function automatic res_t ref_mul(input mat_t a, input mat_t b);
    res_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[2*i+j] = OW'(int'(a[2*i]) * int'(b[j]) + int'(a[2*i+1]) * int'(b[2+j]));
    return r;
  endfunction

  function automatic logic [4*W-1:0] ref_ops(input mat_t a, input mat_t b, input int k);
    int i, j;
    i = k / 2;
    j = k % 2;
    return {a[2*i], a[2*i+1], b[j], b[2+j]};
  endfunction

  function automatic mat_t m4(input int e0, input int e1, input int e2, input int e3);
    mat_t r;
    r[0] = W'(e0); r[1] = W'(e1); r[2] = W'(e2); r[3] = W'(e3);
    return r;
  endfunction

  function automatic res_t r4(input int e0, input int e1, input int e2, input int e3);
    res_t r;
    r[0] = OW'(e0); r[1] = OW'(e1); r[2] = OW'(e2); r[3] = OW'(e3);
    return r;
  endfunction

  function automatic mat_t rand_mat();
    return mat_t'($urandom);
  endfunction

  function automatic res_t dut_c();
    res_t r;
    r[0] = c00; r[1] = c01; r[2] = c10; r[3] = c11;
    return r;
  endfunction

  task automatic drive_ops(input mat_t a, input mat_t b);
    a00 = a[0]; a01 = a[1]; a10 = a[2]; a11 = a[3];
    b00 = b[0]; b01 = b[1]; b10 = b[2]; b11 = b[3];
  endtask

  task automatic check_c(input string tag, input res_t exp);
    res_t got;
    got = dut_c();
    for (int k = 0; k < 4; k++) check($sformatf("%s_c%0d", tag, k), got[k], exp[k]);
  endtask

  // One full operation; cyc = cycles from accepting edge to the done cycle (0 if never seen).
  task automatic run_op(input string tag, input mat_t a, input mat_t b, input int lat, input bit hold,
                        input int restart_at, input bit start_in_done, output int cyc, output int nst);
    int base, busy_lo;
    base = starts_total;
    stub_lat = lat;
    stub_hold = hold;
    cyc = 0;
    nst = 0;
    busy_lo = 0;
    @(negedge clk);
    drive_ops(a, b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_ops(rand_mat(), rand_mat());
    check({tag, "_busy_accept"}, busy, 1);
`ifdef MATMUL_TIMEOUT_EN
    check({tag, "_err_clear"}, err, 0);
`endif
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (!busy) busy_lo++;
      start = (i == restart_at);
      if (i == restart_at) drive_ops(rand_mat(), rand_mat());
    end
    start = 1'b0;
    if (cyc == 0) begin
      check({tag, "_done_seen"}, 0, 1);
      return;
    end
    check({tag, "_busy_held"}, busy_lo, 0);
    check({tag, "_busy_in_done"}, busy, 0);
`ifdef MATMUL_TIMEOUT_EN
    check({tag, "_err_done"}, err, 0);
`endif
    nst = starts_total - base;
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    if (start_in_done) begin
      check({tag, "_done_start_busy"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_done_start_busy2"}, busy, 0);
      check({tag, "_done_start_nostrobe"}, starts_total - base, nst);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   cyc, nst, tb0, lat, base, hits;
    bit   hold;
    mat_t ra, rb;

    drive_ops('0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_ops", {bus.alu_row0, bus.alu_row1, bus.alu_col0, bus.alu_col1}, 0);
    check_c("rst", '0);
`ifdef MATMUL_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{a: m4(1, 0, 0, 1), b: m4(5, 6, 7, 8), c: r4(5, 6, 7, 8)};
    vecs[1] = '{a: m4(1, 2, 3, 4), b: m4(5, 6, 7, 8), c: r4(19, 22, 43, 50)};
    vecs[2] = '{a: m4(255, 255, 255, 255), b: m4(255, 255, 255, 255),
                c: r4(130050, 130050, 130050, 130050)};
    vecs[3] = '{a: m4(2, 3, 0, 1), b: m4(4, 0, 1, 5), c: r4(11, 15, 1, 5)};

    for (int v = 0; v < 4; v++) begin
      tb0 = trace.size();
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, 3, (v % 2) == 0, 0, 1'b0, cyc, nst);
      check($sformatf("vec%0d_latency", v), cyc, 20);
      check($sformatf("vec%0d_nstart", v), nst, 4);
      check_c($sformatf("vec%0d", v), vecs[v].c);
      for (int k = 0; k < 4 && (tb0 + k) < trace.size(); k++)
        check($sformatf("vec%0d_ops%0d", v, k), trace[tb0 + k], ref_ops(vecs[v].a, vecs[v].b, k));
    end

    // start re-pulsed mid-operation and again in the DONE cycle
    run_op("ign", vecs[1].a, vecs[1].b, 3, 1'b1, 6, 1'b1, cyc, nst);
    check("ign_latency", cyc, 20);
    check("ign_nstart", nst, 4);
    check_c("ign", vecs[1].c);

    // reset while element 2 is outstanding
    stub_lat = 3;
    stub_hold = 1'b0;
    base = starts_total;
    @(negedge clk);
    drive_ops(vecs[1].a, vecs[1].b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && (starts_total - base) < 3; i++) @(negedge clk);
    check("rst_mid_reached", starts_total - base, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_alu_start", bus.alu_start, 0);
    check("rst_mid_ops", {bus.alu_row0, bus.alu_row1, bus.alu_col0, bus.alu_col1}, 0);
    check_c("rst_mid", '0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) hits++;
    end
    check("rst_mid_quiet", hits, 0);
    run_op("post_rst", vecs[1].a, vecs[1].b, 3, 1'b0, 0, 1'b0, cyc, nst);
    check("post_rst_latency", cyc, 20);
    check_c("post_rst", vecs[1].c);

    for (int n = 0; n < 24; n++) begin
      ra = rand_mat();
      rb = rand_mat();
      lat = $urandom_range(1, 5);
      hold = (lat >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tb0 = trace.size();
      run_op($sformatf("rnd%0d", n), ra, rb, lat, hold, 0, 1'b0, cyc, nst);
      check($sformatf("rnd%0d_latency", n), cyc, 4 * (lat + 2));
      check($sformatf("rnd%0d_nstart", n), nst, 4);
      check_c($sformatf("rnd%0d", n), ref_mul(ra, rb));
      if (trace.size() > tb0 + 3)
        check($sformatf("rnd%0d_ops3", n), trace[tb0 + 3], ref_ops(ra, rb, 3));
    end

`ifdef MATMUL_TIMEOUT_EN
    // element 1 never completes: done+err after TO WAIT cycles, only c00 written
    stub_lat = 3;
    stub_hold = 1'b0;
    @(negedge clk);
    stall_at = starts_total + 1;
    drive_ops(vecs[1].a, vecs[1].b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    check("to_latency", cyc, 5 + 1 + TO);
    check("to_err", err, 1);
    check_c("to", r4(19, 0, 0, 0));
    @(posedge clk); #1;
    check("to_err_hold", err, 1);
    check("to_done_pulse", done, 0);
    stall_at = -1;
    run_op("after_to", vecs[0].a, vecs[0].b, 3, 1'b0, 0, 1'b0, cyc, nst);
    check("after_to_latency", cyc, 20);
    check_c("after_to", vecs[0].c);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "global timeout");
  end
endmodule
